read_pointer_empty_block: RTL and testbench
===========================================

READ_POINTER_EMPTY_BLOCK -- requirements
Module: read_pointer_empty_block

Interface
REQ-001 SHALL have parameter addr_size, default 3, FIFO memory address width (depth 2^addr_size).
REQ-002 SHALL have parameter data_size, default 8, data word width.
REQ-003 SHALL have parameter almost_empty_level, default 1, fill threshold for almost_empty_o.
REQ-004 SHALL have port read_clock_i  input  1  read-domain clock; the block's only clock.
REQ-005 SHALL have port read_reset_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port write_to_read_pointer_i  input  addr_size+1  Gray write pointer, already synchronized into read domain.
REQ-007 SHALL have port read_data_i  input  data_size  memory word at read_address_o, combinational-read memory.
REQ-008 SHALL have port read_ready_i  input  1  consumer accepts read_data_o this cycle.
REQ-009 SHALL have port read_address_o  output  addr_size  binary memory read address.
REQ-010 SHALL have port read_pointer_o  output  addr_size+1  Gray read pointer, to read-to-write synchronizer.
REQ-011 SHALL have port read_data_o  output  data_size  first-word-fall-through output data.
REQ-012 SHALL have port read_valid_o  output  1  read_data_o holds an unconsumed word.
REQ-013 SHALL have port empty_o  output  1  memory holds no unfetched word.
REQ-014 SHALL have port almost_empty_o  output  1  fill_level_o <= almost_empty_level.
REQ-015 SHALL have port fill_level_o  output  addr_size+1  unfetched words in memory, per synchronized view.

Function
REQ-016 SHALL keep a registered binary read pointer rbin (addr_size+1 bits) and a registered Gray copy rgray; read_pointer_o = rgray, read_address_o = rbin[addr_size-1:0].
REQ-017 SHALL define fetch = ~empty_o & (~read_valid_o | read_ready_i); no fetch ever occurs while empty_o=1 (no underflow).
REQ-018 SHALL compute rbin_next = rbin + fetch, modulo 2^(addr_size+1), and rgray_next = (rbin_next >> 1) ^ rbin_next; both registered every edge.
REQ-019 SHALL register empty_o <= (rgray_next == write_to_read_pointer_i); deassertion lags a write-pointer change by exactly one read_clock_i edge.
REQ-020 SHALL, on fetch, register read_data_o <= read_data_i and read_valid_o <= 1, in the same edge as the pointer advance.
REQ-021 SHALL, without fetch, clear read_valid_o when read_ready_i=1, and hold read_valid_o and read_data_o stable when read_ready_i=0.
REQ-022 SHALL sustain one word per cycle when read_ready_i=1 and memory non-empty (fetch and consume in the same cycle).
REQ-023 SHALL register fill_level_o <= gray2bin(write_to_read_pointer_i) - rbin_next, modulo 2^(addr_size+1).
REQ-024 SHALL register almost_empty_o <= (that next fill level <= almost_empty_level).
REQ-025 SHALL wrap rbin from 2^(addr_size+1)-1 to 0 seamlessly; the MSB distinguishes laps, so equal Gray pointers mean empty.

Reset
REQ-026 SHALL, while read_reset_i=1, asynchronously force rbin=0, rgray=0, read_data_o=0, read_valid_o=0, empty_o=1, almost_empty_o=1, fill_level_o=0.
REQ-027 SHALL, on reset mid-transfer, discard the held output word; no word is presented after reset until a new fetch.

Structure
REQ-028 SHALL take Gray-to-binary conversion from one sub-module, gray_to_binary_block, parameterized by addr_size+1.
REQ-029 SHALL place the default addr_size/data_size values in the shared FIFO parameter header used by all FIFO blocks.

Verification (addr_size=3)
REQ-030 SHALL cover reset: read_reset_i=1 -> empty_o=1, read_valid_o=0, read_pointer_o=0000, read_address_o=000, fill_level_o=0, almost_empty_o=1.
REQ-031 SHALL cover single word: write_to_read_pointer_i=0001, read_ready_i=0 -> edge 1 empty_o=0; edge 2 read_valid_o=1, read_data_o=mem[0], read_pointer_o=0001, empty_o=1.
REQ-032 SHALL cover streaming: write_to_read_pointer_i=1100 (bin 8), read_ready_i=1 -> mem[0..7] on 8 consecutive cycles, final read_pointer_o=1100, empty_o=1, fill_level_o=0.
REQ-033 SHALL cover backpressure: read_valid_o=1, read_ready_i=0 for 5 cycles with 3 words pending -> read_data_o, read_pointer_o constant, fill_level_o=3.
REQ-034 SHALL cover wrap: rbin=15 (read_pointer_o=1000), write_to_read_pointer_i=0000 -> one fetch, read_pointer_o=0000, read_address_o=000, empty_o=1.
REQ-035 SHALL cover reset mid-stream: read_reset_i pulse while read_valid_o=1 -> all outputs at REQ-026 values immediately, before the next clock edge.

Source files
------------

// File: rtl/read_pointer_empty_block_pkg.sv
// Shared FIFO parameter header: default geometry used by every FIFO block.
package read_pointer_empty_block_pkg;

   localparam int unsigned fifo_addr_size          = 3;
   localparam int unsigned fifo_data_size          = 8;
   localparam int unsigned fifo_almost_empty_level = 1;

endpackage : read_pointer_empty_block_pkg

// File: rtl/read_pointer_empty_block_gray_to_binary.sv
// Reflected-Gray to binary conversion; each binary bit is the XOR of all Gray bits at or above it.
module gray_to_binary_block #(
   parameter int width = 4
) (
   input  logic [width-1:0] gray_value,
   output logic [width-1:0] binary_value
);

   always_comb begin
      binary_value = '0;
      for (int i = 0; i < width; i++) begin
         binary_value[i] = ^(gray_value >> i);
      end
   end

endmodule : gray_to_binary_block

// File: rtl/read_pointer_empty_block.sv
// Read side of an async FIFO: Gray read pointer, empty/almost-empty flags and
// a one-word first-word-fall-through output register.
module read_pointer_empty_block
   import read_pointer_empty_block_pkg::*;
#(
   parameter int addr_size          = fifo_addr_size,
   parameter int data_size          = fifo_data_size,
   parameter int almost_empty_level = fifo_almost_empty_level
) (
   input  logic                 read_clock_i,
   input  logic                 read_reset_i,
   input  logic [addr_size:0]   write_to_read_pointer_i,
   input  logic [data_size-1:0] read_data_i,
   input  logic                 read_ready_i,
   output logic [addr_size-1:0] read_address_o,
   output logic [addr_size:0]   read_pointer_o,
   output logic [data_size-1:0] read_data_o,
   output logic                 read_valid_o,
   output logic                 empty_o,
   output logic                 almost_empty_o,
   output logic [addr_size:0]   fill_level_o
);

   localparam logic [addr_size:0] ae_level = (addr_size+1)'(almost_empty_level);

   logic [addr_size:0] rbin;
   logic [addr_size:0] rgray;
   logic [addr_size:0] rbin_next;
   logic [addr_size:0] rgray_next;
   logic [addr_size:0] wbin;
   logic [addr_size:0] fill_next;
   logic               fetch;

   gray_to_binary_block #(
      .width (addr_size + 1)
   ) u_write_pointer_to_binary (
      .gray_value   (write_to_read_pointer_i),
      .binary_value (wbin)
   );

   // The output register is refilled whenever it is free or being drained this cycle.
   assign fetch      = ~empty_o & (~read_valid_o | read_ready_i);
   assign rbin_next  = rbin + {{addr_size{1'b0}}, fetch};
   assign rgray_next = (rbin_next >> 1) ^ rbin_next;
   assign fill_next  = wbin - rbin_next;

   // NOTE: every register here is plain flop state (no memory array), so all of it,
   // including the data word, is cleared by the async reset; <= keeps updates edge-atomic.
   always_ff @(posedge read_clock_i or posedge read_reset_i) begin
      if (read_reset_i) begin
         rbin           <= '0;
         rgray          <= '0;
         read_data_o    <= '0;
         read_valid_o   <= 1'b0;
         empty_o        <= 1'b1;
         almost_empty_o <= 1'b1;
         fill_level_o   <= '0;
      end else begin
         rbin           <= rbin_next;
         rgray          <= rgray_next;
         empty_o        <= (rgray_next == write_to_read_pointer_i);
         fill_level_o   <= fill_next;
         almost_empty_o <= (fill_next <= ae_level);
         if (fetch) begin
            read_data_o  <= read_data_i;
            read_valid_o <= 1'b1;
         end else if (read_ready_i) begin
            read_valid_o <= 1'b0;
         end
      end
   end

   assign read_pointer_o = rgray;
   assign read_address_o = rbin[addr_size-1:0];

endmodule : read_pointer_empty_block

// File: tb/tb_read_pointer_empty_block.sv
// Directed bench for read_pointer_empty_block at addr_size=3, data_size=8.
module tb_read_pointer_empty_block;

   logic       clk;
   logic       rst;
   logic [3:0] wptr;
   logic       ready;
   logic [7:0] read_data;
   logic [2:0] read_address;
   logic [3:0] read_pointer;
   logic [7:0] data_out;
   logic       valid;
   logic       empty;
   logic       almost_empty;
   logic [3:0] fill_level;

   logic [7:0] mem [8];
   int passed = 0;
   int total  = 0;

   assign read_data = mem[read_address];

   read_pointer_empty_block #(
      .addr_size          (3),
      .data_size          (8),
      .almost_empty_level (1)
   ) dut (
      .read_clock_i            (clk),
      .read_reset_i            (rst),
      .write_to_read_pointer_i (wptr),
      .read_data_i             (read_data),
      .read_ready_i            (ready),
      .read_address_o          (read_address),
      .read_pointer_o          (read_pointer),
      .read_data_o             (data_out),
      .read_valid_o            (valid),
      .empty_o                 (empty),
      .almost_empty_o          (almost_empty),
      .fill_level_o            (fill_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] wptr;
      logic       ready;
      logic       exp_empty;
      logic       exp_valid;
      logic [3:0] exp_rptr;
      logic [3:0] exp_fill;
      logic       exp_ae;
      logic       chk_data;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual === expected) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      wptr  = 4'b0000;
      ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " empty"},        32'(empty),        32'd1);
      check({tag, " valid"},        32'(valid),        32'd0);
      check({tag, " rptr"},         32'(read_pointer), 32'd0);
      check({tag, " addr"},         32'(read_address), 32'd0);
      check({tag, " fill"},         32'(fill_level),   32'd0);
      check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
      check({tag, " data"},         32'(data_out),     32'd0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'(8'h0F + 8'h10 * i);
      rst   = 1'b1;
      wptr  = 4'b0000;
      ready = 1'b0;

      // Single word arrival, hold, drain, then a two-word burst.
      vecs[0] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b1, 1'b1, 8'h00};
      vecs[1] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd1, 1'b1, 1'b1, 8'h00};
      vecs[2] = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 4'd0, 1'b1, 1'b1, 8'h0F};
      vecs[3] = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 4'd0, 1'b1, 1'b1, 8'h0F};
      vecs[4] = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, 4'd0, 1'b1, 1'b0, 8'h00};
      vecs[5] = '{1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0001, 4'd2, 1'b0, 1'b0, 8'h00};
      vecs[6] = '{1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0011, 4'd1, 1'b1, 1'b1, 8'h1F};
      vecs[7] = '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010, 4'd0, 1'b1, 1'b1, 8'h2F};
      vecs[8] = '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010, 4'd0, 1'b1, 1'b0, 8'h00};

      #1;
      check_reset_values("async reset");

      for (int v = 0; v < 9; v++) begin
         rst   = vecs[v].rst;
         wptr  = vecs[v].wptr;
         ready = vecs[v].ready;
         tick();
         check($sformatf("vec%0d empty", v),        32'(empty),        32'(vecs[v].exp_empty));
         check($sformatf("vec%0d valid", v),        32'(valid),        32'(vecs[v].exp_valid));
         check($sformatf("vec%0d rptr", v),         32'(read_pointer), 32'(vecs[v].exp_rptr));
         check($sformatf("vec%0d fill", v),         32'(fill_level),   32'(vecs[v].exp_fill));
         check($sformatf("vec%0d almost_empty", v), 32'(almost_empty), 32'(vecs[v].exp_ae));
         if (vecs[v].chk_data)
            check($sformatf("vec%0d data", v),      32'(data_out),     32'(vecs[v].exp_data));
      end

      // Streaming: eight words at one per cycle.
      do_reset();
      check_reset_values("stream reset");
      wptr  = 4'b1100;
      ready = 1'b1;
      tick();
      check("stream edge1 empty", 32'(empty), 32'd0);
      check("stream edge1 fill", 32'(fill_level), 32'd8);
      check("stream edge1 almost_empty", 32'(almost_empty), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("stream w%0d valid", i), 32'(valid), 32'd1);
         check($sformatf("stream w%0d data", i), 32'(data_out), 32'(mem[i]));
         check($sformatf("stream w%0d fill", i), 32'(fill_level), 32'(7 - i));
      end
      check("stream final rptr", 32'(read_pointer), 32'b1100);
      check("stream final empty", 32'(empty), 32'd1);
      check("stream final almost_empty", 32'(almost_empty), 32'd1);

      // Backpressure with three words still pending, then reset mid-transfer.
      do_reset();
      wptr  = 4'b0110;
      ready = 1'b0;
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("bp c%0d valid", c), 32'(valid), 32'd1);
         check($sformatf("bp c%0d data", c), 32'(data_out), 32'(mem[0]));
         check($sformatf("bp c%0d rptr", c), 32'(read_pointer), 32'b0001);
         check($sformatf("bp c%0d fill", c), 32'(fill_level), 32'd3);
      end
      rst = 1'b1;
      #1;
      check_reset_values("midstream reset");
      tick();
      rst = 1'b0;
      tick();
      check("post reset no word", 32'(valid), 32'd0);
      check("post reset empty", 32'(empty), 32'd0);
      check("post reset fill", 32'(fill_level), 32'd4);
      tick();
      check("post reset refetch valid", 32'(valid), 32'd1);
      check("post reset refetch data", 32'(data_out), 32'(mem[0]));

      // Wrap: advance rbin to 15, then fetch across the 15 -> 0 boundary.
      do_reset();
      wptr  = 4'b1000;
      ready = 1'b1;
      for (int c = 0; c < 16; c++) tick();
      check("wrap pre rptr", 32'(read_pointer), 32'b1000);
      check("wrap pre addr", 32'(read_address), 32'd7);
      check("wrap pre empty", 32'(empty), 32'd1);
      check("wrap pre data", 32'(data_out), 32'(mem[6]));
      wptr = 4'b0000;
      tick();
      check("wrap arm empty", 32'(empty), 32'd0);
      check("wrap arm fill", 32'(fill_level), 32'd1);
      tick();
      check("wrap rptr", 32'(read_pointer), 32'b0000);
      check("wrap addr", 32'(read_address), 32'd0);
      check("wrap empty", 32'(empty), 32'd1);
      check("wrap valid", 32'(valid), 32'd1);
      check("wrap data", 32'(data_out), 32'(mem[7]));
      check("wrap fill", 32'(fill_level), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_read_pointer_empty_block
